// File: rtl/fetch_unit_pkg.sv
// Shared fetch-unit types and default configuration constants.
package fetch_unit_pkg;

  localparam int DEFAULT_XLEN        = 24;
  localparam int DEFAULT_INSTR_BYTES = 3;
  localparam int DEFAULT_FIFO_DEPTH  = 4;
  localparam int DEFAULT_RESET_PC    = 10;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_WAIT,
    ST_DROP,
    ST_HALT
  } fetch_state_t;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] word;
    logic [DEFAULT_XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: circular FIFO with push, pop, flush and an occupancy count.
// Flush wins over a simultaneous push or pop.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int WIDTH = 2 * DEFAULT_XLEN,
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop    = pop && (count != '0) && !flush;
  assign do_push   = push && !flush && ((count != CW'(DEPTH)) || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge Clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding fetch FSM, PC sequencing and redirect flush.
// Define FETCH_ALIGN_CHECK_EN to halt with a sticky fetch_fault on a misaligned redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int XLEN        = DEFAULT_XLEN,
  parameter int INSTR_BYTES = DEFAULT_INSTR_BYTES,
  parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
  parameter int RESET_PC    = DEFAULT_RESET_PC
) (
  input  logic            Clock,
  input  logic            Resetn,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_next,
  output logic            fetch_fault
);

  localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

  fetch_state_t      state;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   req_addr;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] head;
  logic              redirect;
  logic              bad_target;
  logic              issue;
  logic              push;
  logic              pop;

  // In FETCH nothing is outstanding, so the buffer count alone bounds the issue.
  assign redirect      = redirect_valid && (state != ST_HALT);
  assign issue         = (state == ST_FETCH) && !redirect_valid && (count < CW'(FIFO_DEPTH));
  assign imem_req      = Resetn && issue;
  assign imem_addr     = pc;
  assign push          = (state == ST_WAIT) && imem_rvalid && !redirect_valid;
  assign pop           = instr_valid && instr_ready;
  assign instr_valid   = (count != '0);
  assign instr_data    = head[2*XLEN-1:XLEN];
  assign instr_pc      = head[XLEN-1:0];
  assign instr_pc_next = instr_pc + PC_STEP;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;

  assign bad_target  = redirect && ((redirect_target % PC_STEP) != '0);
  assign fetch_fault = fault_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      fault_q <= 1'b0;
    end else if (bad_target) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign bad_target  = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  fetch_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .push      (push),
    .push_data ({imem_rdata, req_addr}),
    .pop       (pop),
    .flush     (redirect),
    .head_data (head),
    .count     (count)
  );

  // DROP remembers that one response is still in flight and must be thrown away.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= ST_FETCH;
      pc       <= XLEN'(RESET_PC);
      req_addr <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (bad_target) begin
            state <= ST_HALT;
          end else if (redirect) begin
            pc <= redirect_target;
          end else if (issue) begin
            req_addr <= pc;
            pc       <= pc + PC_STEP;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bad_target) begin
            state <= ST_HALT;
          end else if (redirect) begin
            pc    <= redirect_target;
            state <= imem_rvalid ? ST_FETCH : ST_DROP;
          end else if (imem_rvalid) begin
            state <= ST_FETCH;
          end
        end
        ST_DROP: begin
          if (bad_target) begin
            state <= ST_HALT;
          end else begin
            if (redirect) begin
              pc <= redirect_target;
            end
            if (imem_rvalid) begin
              state <= ST_FETCH;
            end
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, multi-cycle corner sequences and
// randomized traffic checked against a queue-based transaction model.
`timescale 1ns/1ps
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          STEP      = 3;
  localparam int          DEPTH     = 4;
  localparam int unsigned ADDR_SPAN = 32'd1 << 24;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [23:0] REDIR_T   = 24'd39;
  localparam logic [23:0] WRAP_T    = 24'hFFFFFF;
  localparam logic [23:0] WRAP_NEXT = 24'h000002;
`else
  localparam logic [23:0] REDIR_T   = 24'd40;
  localparam logic [23:0] WRAP_T    = 24'hFFFFFE;
  localparam logic [23:0] WRAP_NEXT = 24'h000001;
`endif

  logic        Clock;
  logic        Resetn;
  logic        imem_req;
  logic [23:0] imem_addr;
  logic        imem_rvalid;
  logic [23:0] imem_rdata;
  logic        redirect_valid;
  logic [23:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [23:0] instr_data;
  logic [23:0] instr_pc;
  logic [23:0] instr_pc_next;
  logic        fetch_fault;

  fetch_unit #(
    .XLEN        (24),
    .INSTR_BYTES (STEP),
    .FIFO_DEPTH  (DEPTH),
    .RESET_PC    (10)
  ) dut (
    .Clock           (Clock),
    .Resetn          (Resetn),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc),
    .instr_pc_next   (instr_pc_next),
    .fetch_fault     (fetch_fault)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Transaction-level model: buffer queue, next PC, one in-flight request.
  fetch_entry_t mq[$];
  int unsigned  m_pc;
  int unsigned  m_issued;
  bit           m_out;
  bit           m_discard;
  bit           m_halt;
  bit           m_fault;
  bit           e_req;
  bit           e_valid;
  int           resp_wait;

  logic        d_rv, d_rsp, d_rdy;
  logic [23:0] d_tgt, d_data;
  logic        s_req, s_valid, s_fault;
  logic [23:0] s_addr, s_pc, s_data, s_pc_next;

  typedef struct {
    logic        rsp;
    logic [23:0] data;
    logic        rdy;
    logic        exp_req;
    logic [23:0] exp_addr;
    logic        exp_valid;
    logic [23:0] exp_pc;
    logic [23:0] exp_data;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%06h, expected 0x%06h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc      = 10;
    m_issued  = 0;
    m_out     = 1'b0;
    m_discard = 1'b0;
    m_halt    = 1'b0;
    m_fault   = 1'b0;
    resp_wait = 0;
  endtask

  task automatic check_output();
    check("imem_req", imem_req, e_req);
    if (e_req) check("imem_addr", imem_addr, 24'(m_pc));
    check("instr_valid", instr_valid, e_valid);
    if (e_valid) begin
      check("instr_data", instr_data, mq[0].word);
      check("instr_pc", instr_pc, mq[0].pc);
      check("instr_pc_next", instr_pc_next, 24'((int'(mq[0].pc) + STEP) % ADDR_SPAN));
    end
    check("fetch_fault", fetch_fault, m_fault);
  endtask

  task automatic apply_stimulus(input logic rv, input logic [23:0] tgt, input logic rsp,
                                input logic [23:0] data, input logic rdy);
    redirect_valid  = rv;
    redirect_target = tgt;
    imem_rvalid     = rsp;
    imem_rdata      = data;
    instr_ready     = rdy;
    d_rv = rv; d_tgt = tgt; d_rsp = rsp; d_data = data; d_rdy = rdy;
    e_req   = !m_halt && !m_out && !rv && (mq.size() < DEPTH);
    e_valid = (mq.size() > 0);
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid; s_pc = instr_pc;
    s_data = instr_data; s_pc_next = instr_pc_next; s_fault = fetch_fault;
    check_output();
  endtask

  task automatic model_update();
    bit bad;
    if (m_halt) return;
    if (d_rv) begin
      bad = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      bad = (int'(d_tgt) % STEP) != 0;
`endif
      if (bad) begin
        m_halt  = 1'b1;
        m_fault = 1'b1;
      end
      mq.delete();
      m_pc = d_tgt;
      if (m_out) begin
        if (d_rsp) begin
          m_out = 1'b0;
          m_discard = 1'b0;
        end else begin
          m_discard = 1'b1;
        end
      end
    end else begin
      if (e_valid && d_rdy) void'(mq.pop_front());
      if (m_out && d_rsp) begin
        if (!m_discard) mq.push_back('{word: d_data, pc: 24'(m_issued)});
        m_out = 1'b0;
        m_discard = 1'b0;
      end
      if (e_req) begin
        m_out    = 1'b1;
        m_issued = m_pc;
        m_pc     = (m_pc + STEP) % ADDR_SPAN;
      end
    end
  endtask

  task automatic clock_cycle();
    @(posedge Clock);
    model_update();
    cyc++;
    @(negedge Clock);
  endtask

  task automatic auto_cycle(input logic rdy, input logic rv, input logic [23:0] tgt,
                            input int lat, input bit spurious);
    logic rsp;
    rsp = 1'b0;
    if (resp_wait > 0) begin
      resp_wait--;
      if (resp_wait == 0) rsp = 1'b1;
    end else if (spurious && !m_out && $urandom_range(0, 9) == 0) begin
      rsp = 1'b1;
    end
    apply_stimulus(rv, tgt, rsp, 24'($urandom), rdy);
    clock_cycle();
    if (e_req) resp_wait = lat;
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0; imem_rvalid = 1'b0;
    imem_rdata = '0; instr_ready = 1'b0;
    #1;
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_fetch_fault", fetch_fault, 1'b0);
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n_req;
    int first_addr;
    bit fired, seen_first, stale, resumed;
    int halt_cnt;
    logic [23:0] popped[$];
    logic [23:0] tgt;

    vecs[0] = '{1'b0, 24'h000000, 1'b1, 1'b1, 24'd10, 1'b0, 24'd0,  24'h000000};
    vecs[1] = '{1'b1, 24'hA00000, 1'b1, 1'b0, 24'd0,  1'b0, 24'd0,  24'h000000};
    vecs[2] = '{1'b0, 24'h000000, 1'b1, 1'b1, 24'd13, 1'b1, 24'd10, 24'hA00000};
    vecs[3] = '{1'b1, 24'hA00001, 1'b1, 1'b0, 24'd0,  1'b0, 24'd0,  24'h000000};
    vecs[4] = '{1'b0, 24'h000000, 1'b1, 1'b1, 24'd16, 1'b1, 24'd13, 24'hA00001};
    vecs[5] = '{1'b1, 24'hA00002, 1'b1, 1'b0, 24'd0,  1'b0, 24'd0,  24'h000000};
    vecs[6] = '{1'b0, 24'h000000, 1'b1, 1'b1, 24'd19, 1'b1, 24'd16, 24'hA00002};
    vecs[7] = '{1'b1, 24'hA00003, 1'b1, 1'b0, 24'd0,  1'b0, 24'd0,  24'h000000};
    vecs[8] = '{1'b0, 24'h000000, 1'b1, 1'b1, 24'd22, 1'b1, 24'd19, 24'hA00003};

    Resetn = 1'b0;
    @(negedge Clock);
    do_reset();

    $display("[TB] sequential fetch vector table");
    foreach (vecs[i]) begin
      apply_stimulus(1'b0, 24'h0, vecs[i].rsp, vecs[i].data, vecs[i].rdy);
      check("vec_req", s_req, vecs[i].exp_req);
      if (vecs[i].exp_req) check("vec_addr", s_addr, vecs[i].exp_addr);
      check("vec_valid", s_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check("vec_pc", s_pc, vecs[i].exp_pc);
        check("vec_data", s_data, vecs[i].exp_data);
        check("vec_pc_next", s_pc_next, vecs[i].exp_pc + 24'd3);
      end
      clock_cycle();
    end

    $display("[TB] reset abandons outstanding request, late response ignored");
    do_reset();
    apply_stimulus(1'b0, 24'h0, 1'b1, 24'hBADBAD, 1'b1);
    check("late_first_req", s_req, 1'b1);
    check("late_first_addr", s_addr, 24'd10);
    clock_cycle();
    apply_stimulus(1'b0, 24'h0, 1'b0, 24'h0, 1'b1);
    check("late_no_push", s_valid, 1'b0);
    clock_cycle();
    apply_stimulus(1'b0, 24'h0, 1'b1, 24'hC0FFEE, 1'b1);
    clock_cycle();
    apply_stimulus(1'b0, 24'h0, 1'b0, 24'h0, 1'b1);
    check("late_real_data", s_data, 24'hC0FFEE);
    clock_cycle();

    $display("[TB] back-pressure fills buffer");
    do_reset();
    n_req = 0;
    for (int i = 0; i < 14; i++) begin
      auto_cycle(1'b0, 1'b0, 24'h0, 1, 1'b0);
      if (s_req) n_req++;
    end
    check("full_req_count", 24'(n_req), 24'd4);
    popped.delete();
    resumed = 1'b0;
    for (int i = 0; i < 12; i++) begin
      auto_cycle(1'b1, 1'b0, 24'h0, 1, 1'b0);
      if (s_valid) popped.push_back(s_pc);
      if (s_req) resumed = 1'b1;
    end
    check("full_pop_n", 24'(popped.size() >= 4), 24'd1);
    if (popped.size() >= 4) begin
      check("full_pop0", popped[0], 24'd10);
      check("full_pop1", popped[1], 24'd13);
      check("full_pop2", popped[2], 24'd16);
      check("full_pop3", popped[3], 24'd19);
    end
    check("full_resumed", resumed, 1'b1);

    $display("[TB] redirect while waiting on address 16");
    do_reset();
    fired = 1'b0; seen_first = 1'b0; stale = 1'b0; first_addr = 0;
    for (int i = 0; i < 24; i++) begin
      if (!fired && m_out && m_issued == 16) begin
        auto_cycle(1'b1, 1'b1, REDIR_T, 2, 1'b0);
        fired = 1'b1;
      end else begin
        auto_cycle(1'b1, 1'b0, 24'h0, 2, 1'b0);
        if (fired && s_req && !seen_first) begin
          seen_first = 1'b1;
          first_addr = int'(s_addr);
        end
        if (fired && s_valid && s_pc == 24'd16) stale = 1'b1;
      end
    end
    check("drop_fired", fired, 1'b1);
    check("drop_first_addr", 24'(first_addr), REDIR_T);
    check("drop_no_stale", stale, 1'b0);

    $display("[TB] redirect with response and pop in same cycle");
    do_reset();
    apply_stimulus(1'b0, 24'h0, 1'b0, 24'h0, 1'b0);
    clock_cycle();
    apply_stimulus(1'b0, 24'h0, 1'b1, 24'h123456, 1'b0);
    clock_cycle();
    apply_stimulus(1'b0, 24'h0, 1'b0, 24'h0, 1'b0);
    clock_cycle();
    apply_stimulus(1'b1, 24'd60, 1'b1, 24'h654321, 1'b1);
    check("coinc_valid_before", s_valid, 1'b1);
    clock_cycle();
    apply_stimulus(1'b0, 24'h0, 1'b0, 24'h0, 1'b1);
    check("coinc_empty", s_valid, 1'b0);
    check("coinc_req", s_req, 1'b1);
    check("coinc_addr", s_addr, 24'd60);
    clock_cycle();

    $display("[TB] PC wrap at top of address space");
    do_reset();
    apply_stimulus(1'b1, WRAP_T, 1'b0, 24'h0, 1'b1);
    check("wrap_redirect_req", s_req, 1'b0);
    clock_cycle();
    apply_stimulus(1'b0, 24'h0, 1'b0, 24'h0, 1'b1);
    check("wrap_first_addr", s_addr, WRAP_T);
    clock_cycle();
    apply_stimulus(1'b0, 24'h0, 1'b1, 24'h0F0F0F, 1'b1);
    clock_cycle();
    apply_stimulus(1'b0, 24'h0, 1'b0, 24'h0, 1'b1);
    check("wrap_next_addr", s_addr, WRAP_NEXT);
    check("wrap_pc_next", s_pc_next, WRAP_NEXT);
    clock_cycle();

    $display("[TB] redirect to misaligned target 41");
    do_reset();
    apply_stimulus(1'b1, 24'd41, 1'b0, 24'h0, 1'b1);
    clock_cycle();
`ifdef FETCH_ALIGN_CHECK_EN
    n_req = 0;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, 24'h0, 1'b0, 24'h0, 1'b1);
      if (s_req) n_req++;
      if (i == 0) check("align_fault", s_fault, 1'b1);
      clock_cycle();
    end
    check("align_halt_reqs", 24'(n_req), 24'd0);
    do_reset();
    apply_stimulus(1'b0, 24'h0, 1'b0, 24'h0, 1'b1);
    check("align_fault_cleared", s_fault, 1'b0);
    check("align_restart_addr", s_addr, 24'd10);
    clock_cycle();
`else
    apply_stimulus(1'b0, 24'h0, 1'b0, 24'h0, 1'b1);
    check("align_req", s_req, 1'b1);
    check("align_addr", s_addr, 24'd41);
    check("align_no_fault", s_fault, 1'b0);
    clock_cycle();
`endif

    $display("[TB] randomized traffic");
    do_reset();
    halt_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if ((m_halt && ++halt_cnt > 6) || $urandom_range(0, 399) == 0) begin
        halt_cnt = 0;
        do_reset();
      end
`ifdef FETCH_ALIGN_CHECK_EN
      if ($urandom_range(0, 15) == 0) tgt = 24'($urandom);
      else tgt = 24'(($urandom % 32'd5592405) * 3);
`else
      tgt = 24'($urandom);
`endif
      auto_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, tgt,
                 int'($urandom_range(1, 3)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 24, address/instruction width in bits.
REQ-002 Parameter INSTR_BYTES, default 3, PC increment per sequential instruction.
REQ-003 Parameter FIFO_DEPTH, default 4, instruction buffer entries (power of two, >= 2).
REQ-004 Parameter RESET_PC, default 10, PC value loaded on reset.
REQ-005 Clock  in  1  single clock; all state updates on posedge.
REQ-006 Resetn  in  1  asynchronous, active-low reset.
REQ-007 imem_req  out  1  fetch request, valid for one cycle per fetch.
REQ-008 imem_addr  out  XLEN  fetch address; meaningful only while imem_req=1.
REQ-009 imem_rvalid  in  1  response strobe, >= 1 cycle after imem_req.
REQ-010 imem_rdata  in  XLEN  instruction word, valid with imem_rvalid.
REQ-011 redirect_valid  in  1  branch/jump taken; flush and refetch.
REQ-012 redirect_target  in  XLEN  new PC, valid with redirect_valid.
REQ-013 instr_valid  out  1  buffer head holds an instruction.
REQ-014 instr_ready  in  1  consumer accepts head when instr_valid=1.
REQ-015 instr_data  out  XLEN  head instruction word.
REQ-016 instr_pc  out  XLEN  address of head instruction.
REQ-017 instr_pc_next  out  XLEN  instr_pc + INSTR_BYTES, modulo 2^XLEN.
REQ-018 fetch_fault  out  1  misaligned redirect seen (sticky; 0 when macro absent).

Function
REQ-019 FSM states: FETCH, WAIT, DROP, HALT; at most one request outstanding.
REQ-020 FETCH: imem_req=1, imem_addr=pc, when (entries + outstanding) < FIFO_DEPTH and redirect_valid=0; then pc <= pc + INSTR_BYTES (wraps mod 2^XLEN), go WAIT.
REQ-021 WAIT: on imem_rvalid, push {imem_rdata, issued address} into buffer, go FETCH; imem_req=0.
REQ-022 Pushed entry visible at instr_valid the cycle after imem_rvalid; minimum issue-to-issue interval 2 cycles.
REQ-023 Pop occurs when instr_valid & instr_ready; push and pop in same cycle both take effect, count unchanged.
REQ-024 Buffer cannot overflow: issue is gated by count including the outstanding request; imem_rvalid in FETCH/HALT is ignored.
REQ-025 redirect_valid (any state except HALT): buffer flushed same cycle, pc <= redirect_target, pop ignored; from WAIT go DROP, otherwise FETCH.
REQ-026 redirect_valid together with imem_rvalid in WAIT: response discarded, go FETCH.
REQ-027 DROP: next imem_rvalid discarded, go FETCH; a further redirect in DROP updates pc only, stays DROP.
REQ-028 First request after redirect to a non-busy unit issues at cycle N+1 with imem_addr=redirect_target.
REQ-029 Outputs instr_data/instr_pc/instr_pc_next are don't-care while instr_valid=0.

Reset
REQ-030 Resetn low: state=FETCH, pc=RESET_PC, buffer empty, no outstanding request, imem_req=0, instr_valid=0, fetch_fault=0.
REQ-031 Reset asserted mid-operation abandons any outstanding request; a late imem_rvalid after release while in FETCH is ignored.
REQ-032 First request issues in the first cycle after Resetn deasserts, with imem_addr=RESET_PC.

Configuration
REQ-033 Macro FETCH_ALIGN_CHECK_EN defined: redirect_target mod INSTR_BYTES != 0 sets fetch_fault=1, flushes buffer, enters HALT (no requests, instr_valid=0) until reset.
REQ-034 Macro absent: no alignment check, misaligned targets fetched as given, fetch_fault tied 0, HALT unreachable.

Structure
REQ-035 Shared package holds the FSM state enum, default XLEN/INSTR_BYTES/RESET_PC constants, and the buffer entry type {word, pc}.
REQ-036 Buffer implemented as one sub-module fetch_fifo (parametrised width/depth, push/pop/flush, count output); FSM and PC logic stay in fetch_unit.

Verification
REQ-037 Reset release, imem_rvalid 1 cycle after each request, instr_ready=1: addresses 10,13,16,19; instr_pc matches, instr_pc_next = instr_pc+3.
REQ-038 instr_ready=0, DEPTH=4: exactly 4 requests issued then imem_req stays 0; on ready, 4 pops in order, fetching resumes.
REQ-039 Redirect to 40 while WAIT on address 16: response for 16 discarded, next request addr 40, no stale instruction reaches instr_valid.
REQ-040 Redirect coinciding with imem_rvalid and with a pop: buffer empty next cycle, next imem_addr=target.
REQ-041 pc=0xFFFFFE sequential fetch: next imem_addr=0x000001 (wrap).
REQ-042 With FETCH_ALIGN_CHECK_EN, redirect to 41: fetch_fault=1, no further imem_req until Resetn pulse; without macro, request issues at 41.
